// File: rtl/fpga_lmmi_req_bridge_if.sv
// Signal bundle between the SPI register table (up_*) and two hard-IP LMMI slaves (ip_*).
// The bridge takes the master view; the register table and slaves together take the slave view.
interface fpga_lmmi_req_bridge_if;
    logic [1:0]      up_request;
    logic            up_wr_rdn;
    logic [7:0]      up_offset;
    logic [7:0]      up_wdata;
    logic [1:0]      up_ready;
    logic [1:0][7:0] up_rdata;
    logic [1:0]      up_rdata_valid;
    logic [1:0]      up_timeout;

    logic [1:0]      ip_request;
    logic            ip_wr_rdn;
    logic [7:0]      ip_offset;
    logic [7:0]      ip_wdata;
    logic [1:0]      ip_ready;
    logic [1:0][7:0] ip_rdata;
    logic [1:0]      ip_rdata_valid;

    modport master (
        input  up_request, up_wr_rdn, up_offset, up_wdata,
        output up_ready, up_rdata, up_rdata_valid, up_timeout,
        output ip_request, ip_wr_rdn, ip_offset, ip_wdata,
        input  ip_ready, ip_rdata, ip_rdata_valid
    );

    modport slave (
        output up_request, up_wr_rdn, up_offset, up_wdata,
        input  up_ready, up_rdata, up_rdata_valid, up_timeout,
        input  ip_request, ip_wr_rdn, ip_offset, ip_wdata,
        output ip_ready, ip_rdata, ip_rdata_valid
    );
endinterface

// File: rtl/fpga_lmmi_req_bridge.sv
// Converts level-style per-port request bits into single-beat LMMI transactions on two slaves,
// one at a time with port 0 priority, guarded by a timeout against a hung slave.
module fpga_lmmi_req_bridge #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] TIMEOUT_RDATA  = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fpga_lmmi_req_bridge_if.master bus
);

    localparam int             TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    state_t          state_q, state_d;
    logic            sel_q, sel_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      pending_q, pending_d;
    logic [1:0]      reqPrev_q;
    logic            cmdWrRdn_q, cmdWrRdn_d;
    logic [7:0]      cmdOffset_q, cmdOffset_d;
    logic [7:0]      cmdWdata_q, cmdWdata_d;
    logic [1:0]      ready_q, ready_d;
    logic [1:0][7:0] rdata_q, rdata_d;
    logic [1:0]      rdValid_q, rdValid_d;
    logic [1:0]      timeout_q, timeout_d;

    logic [1:0]      rise, accept;
    logic            timerHit;

    assign rise     = bus.up_request & ~reqPrev_q;
    assign accept   = rise & ~pending_q;
    assign timerHit = (timer_q == TLAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            timer_q     <= '0;
            pending_q   <= '0;
            reqPrev_q   <= '0;
            cmdWrRdn_q  <= 1'b0;
            cmdOffset_q <= '0;
            cmdWdata_q  <= '0;
            ready_q     <= 2'b11;
            rdata_q     <= '0;
            rdValid_q   <= '0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
            reqPrev_q   <= bus.up_request;
            cmdWrRdn_q  <= cmdWrRdn_d;
            cmdOffset_q <= cmdOffset_d;
            cmdWdata_q  <= cmdWdata_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            rdValid_q   <= rdValid_d;
            timeout_q   <= timeout_d;
        end
    end

    // The command register is shared by both ports; the register table only loads one at a time.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        pending_d   = pending_q;
        cmdWrRdn_d  = cmdWrRdn_q;
        cmdOffset_d = cmdOffset_q;
        cmdWdata_d  = cmdWdata_q;
        rdata_d     = rdata_q;
        rdValid_d   = '0;
        timeout_d   = timeout_q;
        ready_d     = ready_q;

        if (|accept) begin
            cmdWrRdn_d  = bus.up_wr_rdn;
            cmdOffset_d = bus.up_offset;
            cmdWdata_d  = bus.up_wdata;
        end
        for (int n = 0; n < 2; n++) begin
            if (accept[n]) begin
                pending_d[n] = 1'b1;
                timeout_d[n] = 1'b0;
            end
        end

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (|pending_q) begin
                    sel_d   = ~pending_q[0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = timerHit ? timer_q : timer_q + TW'(1);
                if (bus.ip_ready[sel_q]) begin
                    state_d = cmdWrRdn_q ? DONE : WAIT_RD;
                end else if (timerHit) begin
                    timeout_d[sel_q] = 1'b1;
                    if (!cmdWrRdn_q) begin
                        rdata_d[sel_q]   = TIMEOUT_RDATA;
                        rdValid_d[sel_q] = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            WAIT_RD: begin
                timer_d = timerHit ? timer_q : timer_q + TW'(1);
                if (bus.ip_rdata_valid[sel_q]) begin
                    rdata_d[sel_q]   = bus.ip_rdata[sel_q];
                    rdValid_d[sel_q] = 1'b1;
                    state_d          = DONE;
                end else if (timerHit) begin
                    timeout_d[sel_q] = 1'b1;
                    rdata_d[sel_q]   = TIMEOUT_RDATA;
                    rdValid_d[sel_q] = 1'b1;
                    state_d          = DONE;
                end
            end
            DONE: begin
                pending_d[sel_q] = 1'b0;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase

        for (int n = 0; n < 2; n++) begin
            ready_d[n] = ~pending_d[n] & ~((state_d != IDLE) && (sel_d == n[0]));
        end
    end

    assign bus.ip_request     = (state_q == ISSUE) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.ip_wr_rdn      = cmdWrRdn_q;
    assign bus.ip_offset      = cmdOffset_q;
    assign bus.ip_wdata       = cmdWdata_q;
    assign bus.up_ready       = ready_q;
    assign bus.up_rdata       = rdata_q;
    assign bus.up_rdata_valid = rdValid_q;
    assign bus.up_timeout     = timeout_q;

endmodule
